// File: rtl/adaptive_filter_ctrlport_master.sv
// CtrlPort initiator: turns a command stream into single-outstanding CtrlPort
// read/write transactions and returns one status/readback word per command.
// Optional write read-back verification is compiled in when the macro
// ADAPTIVE_FILTER_CTRLPORT_VERIFY_EN is defined.
// Status codes: 0 OK, 1 TIMEOUT, 2 VERIFY_FAIL.
module adaptive_filter_ctrlport_master #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        ctrlport_clk,
  input  logic        ctrlport_rst,
  input  logic        s_cmd_valid,
  output logic        s_cmd_ready,
  input  logic        s_cmd_wr,
  input  logic [19:0] s_cmd_addr,
  input  logic [31:0] s_cmd_data,
  output logic        m_ctrlport_req_wr,
  output logic        m_ctrlport_req_rd,
  output logic [19:0] m_ctrlport_req_addr,
  output logic [31:0] m_ctrlport_req_data,
  input  logic        m_ctrlport_resp_ack,
  input  logic [31:0] m_ctrlport_resp_data,
  output logic        m_rsp_valid,
  input  logic        m_rsp_ready,
  output logic [31:0] m_rsp_data,
  output logic [1:0]  m_rsp_status
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    VREQ,
    VWAIT,
    RESP
  } state_t;

  localparam logic [1:0]  ST_OK      = 2'd0;
  localparam logic [1:0]  ST_TIMEOUT = 2'd1;
  localparam logic [1:0]  ST_VERIFY  = 2'd2;
  localparam logic [15:0] CNT_LAST   = 16'(TIMEOUT - 1);

  state_t      state;
  logic        cmd_wr;
  logic [15:0] cnt;

  // Ready is decoded from the state (and gated by reset) so it is low while
  // reset is held and rises in the very first cycle after reset releases.
  assign s_cmd_ready = (state == IDLE) && !ctrlport_rst;

  // Transaction FSM with registered request and response outputs.
  always_ff @(posedge ctrlport_clk) begin
    if (ctrlport_rst) begin
      state               <= IDLE;
      cmd_wr              <= 1'b0;
      cnt                 <= '0;
      m_ctrlport_req_wr   <= 1'b0;
      m_ctrlport_req_rd   <= 1'b0;
      m_ctrlport_req_addr <= '0;
      m_ctrlport_req_data <= '0;
      m_rsp_valid         <= 1'b0;
      m_rsp_data          <= '0;
      m_rsp_status        <= ST_OK;
    end else begin
      m_ctrlport_req_wr <= 1'b0;
      m_ctrlport_req_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (s_cmd_valid) begin
            // The request pulse is registered here so it is on the pins
            // for exactly the cycle the FSM spends in REQ.
            cmd_wr              <= s_cmd_wr;
            m_ctrlport_req_addr <= s_cmd_addr;
            m_ctrlport_req_data <= s_cmd_data;
            m_ctrlport_req_wr   <= s_cmd_wr;
            m_ctrlport_req_rd   <= !s_cmd_wr;
            state               <= REQ;
          end
        end
        REQ: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (m_ctrlport_resp_ack) begin
            m_rsp_status <= ST_OK;
            if (cmd_wr) begin
`ifdef ADAPTIVE_FILTER_CTRLPORT_VERIFY_EN
              m_ctrlport_req_rd <= 1'b1;
              state             <= VREQ;
`else
              m_rsp_data  <= m_ctrlport_req_data;
              m_rsp_valid <= 1'b1;
              state       <= RESP;
`endif
            end else begin
              m_rsp_data  <= m_ctrlport_resp_data;
              m_rsp_valid <= 1'b1;
              state       <= RESP;
            end
          end else if (cnt == CNT_LAST) begin
            m_rsp_data   <= '0;
            m_rsp_status <= ST_TIMEOUT;
            m_rsp_valid  <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`ifdef ADAPTIVE_FILTER_CTRLPORT_VERIFY_EN
        VREQ: begin
          cnt   <= '0;
          state <= VWAIT;
        end
        VWAIT: begin
          if (m_ctrlport_resp_ack) begin
            m_rsp_data   <= m_ctrlport_resp_data;
            m_rsp_status <= (m_ctrlport_resp_data == m_ctrlport_req_data) ? ST_OK : ST_VERIFY;
            m_rsp_valid  <= 1'b1;
            state        <= RESP;
          end else if (cnt == CNT_LAST) begin
            m_rsp_data   <= '0;
            m_rsp_status <= ST_TIMEOUT;
            m_rsp_valid  <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif
        RESP: begin
          if (m_rsp_ready) begin
            m_rsp_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adaptive_filter_ctrlport_master.sv
// Self-checking bench for adaptive_filter_ctrlport_master: a transaction-level
// model predicts request pulses (with cycle), held request pins, ready and the
// response word/arrival cycle; directed tests pin the model with literals.
module tb_adaptive_filter_ctrlport_master;
  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        ctrlport_rst = 1'b1;
  logic        s_cmd_valid = 1'b0;
  logic        s_cmd_ready;
  logic        s_cmd_wr = 1'b0;
  logic [19:0] s_cmd_addr = '0;
  logic [31:0] s_cmd_data = '0;
  logic        req_wr, req_rd;
  logic [19:0] req_addr;
  logic [31:0] req_data;
  logic        resp_ack;
  logic [31:0] resp_data;
  logic        m_rsp_valid;
  logic        m_rsp_ready = 1'b1;
  logic [31:0] m_rsp_data;
  logic [1:0]  m_rsp_status;

  always #5 clk = ~clk;

  adaptive_filter_ctrlport_master #(.TIMEOUT(T)) dut (
    .ctrlport_clk         (clk),
    .ctrlport_rst         (ctrlport_rst),
    .s_cmd_valid          (s_cmd_valid),
    .s_cmd_ready          (s_cmd_ready),
    .s_cmd_wr             (s_cmd_wr),
    .s_cmd_addr           (s_cmd_addr),
    .s_cmd_data           (s_cmd_data),
    .m_ctrlport_req_wr    (req_wr),
    .m_ctrlport_req_rd    (req_rd),
    .m_ctrlport_req_addr  (req_addr),
    .m_ctrlport_req_data  (req_data),
    .m_ctrlport_resp_ack  (resp_ack),
    .m_ctrlport_resp_data (resp_data),
    .m_rsp_valid          (m_rsp_valid),
    .m_rsp_ready          (m_rsp_ready),
    .m_rsp_data           (m_rsp_data),
    .m_rsp_status         (m_rsp_status)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Responder environment: stores every write, acks cur_delay cycles after a
  // request (0 = never acks), plus a manual ack injector.
  int          cur_delay = 1;
  logic [31:0] mask = '1;
  logic [31:0] mem [16];
  logic        ack_r = 1'b0;
  logic        inj = 1'b0;
  logic [31:0] ack_data = '0;
  int          ack_cyc = -1;

  assign resp_ack  = ack_r | inj;
  assign resp_data = ack_data;

  always @(negedge clk) begin
    if (req_wr) mem[req_addr[3:0]] = req_data & mask;
    if ((req_wr || req_rd) && cur_delay > 0) begin
      ack_cyc  = cyc + cur_delay;
      ack_data = mem[req_addr[3:0]];
    end
    ack_r = (cyc == ack_cyc);
  end

  // Transaction-level model.
  typedef struct {
    bit          wr;
    logic [19:0] a;
    logic [31:0] d;
    int          c;
  } req_t;

  req_t        rq[$];
  bit          m_busy = 1'b0;
  bit          m_pend = 1'b0;
  logic [31:0] m_data = '0;
  logic [1:0]  m_stat = '0;
  int          m_vcyc = 0;
  logic [19:0] m_last_addr = '0;
  logic [31:0] m_last_data = '0;
  logic [31:0] mmem [16];

  int          obs_req_cyc = 0;
  int          obs_vcyc = 0;
  logic [31:0] obs_data = '0;
  logic [1:0]  obs_stat = '0;
  bit          v_prev = 1'b0;

  // Compare DUT against the model every cycle, then advance the model to the next edge.
  always @(negedge clk) begin : cmp
    req_t        r;
    bit          ev;
    int          e;
    int          v;
    logic [31:0] rb;
    check("req_exclusive", 32'(req_wr & req_rd), 32'd0);
    check("cmd_ready", 32'(s_cmd_ready), 32'(!ctrlport_rst && !m_busy));
    if (req_wr || req_rd) obs_req_cyc = cyc;
    if (rq.size() > 0 && rq[0].c < cyc) begin
      check("req_missing", 32'd0, 32'd1);
      void'(rq.pop_front());
    end
    if (rq.size() > 0 && rq[0].c == cyc) begin
      r = rq.pop_front();
      m_last_addr = r.a;
      m_last_data = r.d;
      check("req_wr", 32'(req_wr), 32'(r.wr));
      check("req_rd", 32'(req_rd), 32'(!r.wr));
    end else begin
      check("req_spurious", 32'(req_wr | req_rd), 32'd0);
    end
    check("req_addr", 32'(req_addr), 32'(m_last_addr));
    check("req_data", req_data, m_last_data);

    ev = m_pend && (cyc >= m_vcyc);
    check("rsp_valid", 32'(m_rsp_valid), 32'(ev));
    if (ev && m_rsp_valid) begin
      check("rsp_data", m_rsp_data, m_data);
      check("rsp_status", 32'(m_rsp_status), 32'(m_stat));
      if (!v_prev) begin
        obs_vcyc = cyc;
        obs_data = m_rsp_data;
        obs_stat = m_rsp_status;
      end
    end
    v_prev = m_rsp_valid;

    if (ctrlport_rst) begin
      m_busy = 1'b0;
      m_pend = 1'b0;
      rq.delete();
      m_last_addr = '0;
      m_last_data = '0;
    end else begin
      if (ev && m_rsp_ready) begin
        m_pend = 1'b0;
        m_busy = 1'b0;
      end else if (s_cmd_valid && !m_busy) begin
        e = cyc + 1;
        if (s_cmd_wr) mmem[s_cmd_addr[3:0]] = s_cmd_data & mask;
        rq.push_back('{wr: s_cmd_wr, a: s_cmd_addr, d: s_cmd_data, c: e});
        if (cur_delay < 1 || cur_delay > int'(T)) begin
          m_data = '0;
          m_stat = 2'd1;
          m_vcyc = e + int'(T) + 1;
        end else if (!s_cmd_wr) begin
          m_data = mmem[s_cmd_addr[3:0]];
          m_stat = 2'd0;
          m_vcyc = e + cur_delay + 1;
        end else begin
`ifdef ADAPTIVE_FILTER_CTRLPORT_VERIFY_EN
          v = e + cur_delay + 1;
          rq.push_back('{wr: 1'b0, a: s_cmd_addr, d: s_cmd_data, c: v});
          rb = mmem[s_cmd_addr[3:0]];
          m_data = rb;
          m_stat = (rb == s_cmd_data) ? 2'd0 : 2'd2;
          m_vcyc = v + cur_delay + 1;
`else
          v = 0;
          rb = '0;
          m_data = s_cmd_data;
          m_stat = 2'd0;
          m_vcyc = e + cur_delay + 1;
`endif
        end
        m_pend = 1'b1;
        m_busy = 1'b1;
      end
    end
  end

  int acc_cyc = 0;

  task automatic send(input logic wr, input logic [19:0] a, input logic [31:0] d, input int dly);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    s_cmd_valid = 1'b1;
    s_cmd_wr = wr;
    s_cmd_addr = a;
    s_cmd_data = d;
    cur_delay = dly;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_cmd_ready) begin
        ok = 1'b1;
        acc_cyc = cyc + 1;
        break;
      end
    end
    if (!ok) check("cmd_accept_bound", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_rsp_valid && m_rsp_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("rsp_bound", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(s_cmd_ready), 32'd1);
    check({tag, "_wr"}, 32'(req_wr), 32'd0);
    check({tag, "_rd"}, 32'(req_rd), 32'd0);
    check({tag, "_addr"}, 32'(req_addr), 32'd0);
    check({tag, "_data"}, req_data, 32'd0);
    check({tag, "_valid"}, 32'(m_rsp_valid), 32'd0);
    check({tag, "_rdata"}, m_rsp_data, 32'd0);
    check({tag, "_status"}, 32'(m_rsp_status), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      mmem[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_low", 32'(s_cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    ctrlport_rst = 1'b0;
    @(negedge clk);
    check_reset_values("rst_init");

    // Write with next-cycle ack.
    send(1'b1, 20'h0, 32'h199A0000, 1);
    wait_rsp();
    check("t1_data", obs_data, 32'h199A0000);
    check("t1_status", 32'(obs_stat), 32'd0);
`ifndef ADAPTIVE_FILTER_CTRLPORT_VERIFY_EN
    check("t1_req_cycle", 32'(obs_req_cyc - acc_cyc), 32'd0);
    check("t1_rsp_latency", 32'(obs_vcyc - obs_req_cyc), 32'd2);
`endif

    // Read back a stored word.
    send(1'b1, 20'h0, 32'h12345678, 1);
    wait_rsp();
    send(1'b0, 20'h0, 32'h0, 1);
    wait_rsp();
    check("t2_data", obs_data, 32'h12345678);
    check("t2_status", 32'(obs_stat), 32'd0);

    // Unmapped read times out; a late ack afterwards is ignored.
    send(1'b0, 20'h4, 32'h0, 0);
    wait_rsp();
    check("t3_data", obs_data, 32'h0);
    check("t3_status", 32'(obs_stat), 32'd1);
    check("t3_latency", 32'(obs_vcyc - obs_req_cyc), 32'd9);
    repeat (2) @(posedge clk);
    #1;
    inj = 1'b1;
    @(posedge clk);
    #1;
    inj = 1'b0;
    repeat (5) @(posedge clk);

    // Ack on the final wait cycle beats the timeout; one cycle later is a timeout.
    send(1'b0, 20'h0, 32'h0, 8);
    wait_rsp();
    check("t3b_ack_wins_data", obs_data, 32'h12345678);
    check("t3b_ack_wins_status", 32'(obs_stat), 32'd0);
    send(1'b0, 20'h0, 32'h0, 9);
    wait_rsp();
    check("t3c_late_status", 32'(obs_stat), 32'd1);
    repeat (3) @(posedge clk);

    // Response back-pressure with a second command pending.
    #1;
    m_rsp_ready = 1'b0;
    send(1'b1, 20'h5, 32'hCAFE0005, 1);
    repeat (4) @(posedge clk);
    fork
      begin
        repeat (10) @(posedge clk);
        #1;
        m_rsp_ready = 1'b1;
      end
    join_none
    @(negedge clk);
    check("t4_stall_ready", 32'(s_cmd_ready), 32'd0);
    check("t4_stall_data", m_rsp_data, 32'hCAFE0005);
    send(1'b0, 20'h5, 32'h0, 1);
    wait_rsp();
    check("t4_second_data", obs_data, 32'hCAFE0005);
    check("t4_second_status", 32'(obs_stat), 32'd0);

    // Reset during WAIT; the late ack must not produce a response.
    send(1'b1, 20'h2, 32'hDEAD0001, 6);
    repeat (2) @(posedge clk);
    #1;
    ctrlport_rst = 1'b1;
    @(posedge clk);
    #1;
    ctrlport_rst = 1'b0;
    @(negedge clk);
    check_reset_values("rst_mid");
    repeat (10) @(posedge clk);
    send(1'b0, 20'h2, 32'h0, 1);
    wait_rsp();
    check("t5_after_reset_data", obs_data, 32'hDEAD0001);
    check("t5_after_reset_status", 32'(obs_stat), 32'd0);

`ifdef ADAPTIVE_FILTER_CTRLPORT_VERIFY_EN
    // Responder keeps only 16 bits: read-back mismatch.
    mask = 32'h0000FFFF;
    send(1'b1, 20'h3, 32'hABCD1234, 1);
    wait_rsp();
    check("t6_verify_status", 32'(obs_stat), 32'd2);
    check("t6_verify_data", obs_data, 32'h00001234);
`endif

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adaptive_filter_ctrlport_master.md
# adaptive_filter_ctrlport_master

CtrlPort initiator that turns a command stream into single-outstanding CtrlPort read/write transactions and returns one status/readback word per command. It drives the CtrlPort request pins that user-register responders (such as the adaptive-filter `mu` register) consume. It sits on the CtrlPort clock domain between a host-side command source and a block's register responder.

## Interface
- `TIMEOUT`, 64: CtrlPort clock cycles to wait for `resp_ack` before aborting; legal range 2..65535.
- `ctrlport_clk` in 1: clock; all logic on the rising edge.
- `ctrlport_rst` in 1: synchronous, active-high reset.
- `s_cmd_valid` in 1: command valid.
- `s_cmd_ready` out 1: command accepted when valid && ready.
- `s_cmd_wr` in 1: 1 = write, 0 = read.
- `s_cmd_addr` in 20: CtrlPort address.
- `s_cmd_data` in 32: write data; ignored for reads.
- `m_ctrlport_req_wr` out 1: write request pulse.
- `m_ctrlport_req_rd` out 1: read request pulse.
- `m_ctrlport_req_addr` out 20: request address.
- `m_ctrlport_req_data` out 32: request write data.
- `m_ctrlport_resp_ack` in 1: responder acknowledge.
- `m_ctrlport_resp_data` in 32: responder read data, valid with ack.
- `m_rsp_valid` out 1: result valid.
- `m_rsp_ready` in 1: result consumed when valid && ready.
- `m_rsp_data` out 32: read data (reads), echoed write data (writes), 0 on timeout.
- `m_rsp_status` out 2: 0 OK, 1 TIMEOUT, 2 VERIFY_FAIL.

## Operation
- FSM states: IDLE, REQ, WAIT, VREQ, VWAIT, RESP.
- IDLE: `s_cmd_ready`=1. On handshake, latch wr/addr/data -> REQ.
- REQ: assert exactly one of `req_wr`/`req_rd` for one cycle with latched addr/data; clear timeout counter -> WAIT.
- WAIT: counter increments each cycle. `resp_ack`=1 -> capture `resp_data` (read) or latched data (write), status 0 -> RESP (or VREQ, see Configuration). Counter reaching TIMEOUT-1 with no ack -> data 0, status 1 -> RESP.
- Ack and timeout in the same cycle: ack wins.
- RESP: `m_rsp_valid`=1, data/status stable until `m_rsp_ready`; on handshake -> IDLE.
- Ack outside WAIT/VWAIT (stray or late after timeout) is ignored; it never produces a response.
- `req_addr`/`req_data` hold the last issued values between requests; `req_wr`/`req_rd` never both high.
- Reset mid-transaction: return to IDLE, drop the latched command, no response emitted; a later ack is ignored.
- Reset values: `s_cmd_ready`=0 during reset, 1 the first cycle after; `req_wr`=`req_rd`=0; `req_addr`=0; `req_data`=0; `m_rsp_valid`=0; `m_rsp_data`=0; `m_rsp_status`=0.

## Timing
- Accept at edge N -> request pulse in cycle N+1.
- Responder acking one cycle after request: ack in cycle N+2, `m_rsp_valid` in cycle N+3.
- Minimum command-to-command period: 4 cycles with an immediate `m_rsp_ready`.
- Timeout: response valid TIMEOUT+1 cycles after the request pulse.
- One transaction outstanding; `s_cmd_ready` is low from REQ through RESP.

## Configuration
- `ADAPTIVE_FILTER_CTRLPORT_VERIFY_EN` defined: after a write is acked in WAIT, go to VREQ.
  - VREQ issues a one-cycle `req_rd` to the same address -> VWAIT, using the same timeout rules.
  - Readback equal to written data -> status 0. Unequal -> status 2, `m_rsp_data` = readback value. Timeout -> status 1.
- Macro not defined: the VREQ/VWAIT logic is not compiled; writes go WAIT -> RESP directly. Reads are identical in both builds.

## Test plan
- Write 0x199A0000 to addr 0x00, responder acks next cycle -> one `req_wr` pulse at cycle N+1, response data 0x199A0000, status 0, valid at N+3.
- Read addr 0x00 with responder returning 0x12345678 -> one `req_rd` pulse, response data 0x12345678, status 0.
- Read unmapped addr 0x04, TIMEOUT=8 -> response data 0, status 1, valid 9 cycles after the request; an ack injected 2 cycles later produces no response.
- Hold `m_rsp_ready`=0 for 10 cycles with a second command pending -> `s_cmd_ready` stays 0, data/status stable, no new request until the handshake.
- Assert `ctrlport_rst` during WAIT, then ack -> no response; all outputs at reset values; the next command completes normally.
- VERIFY_EN build: responder stores only 16 bits; write 0xABCD1234 -> `req_wr` then `req_rd` to the same address, status 2, data 0x00001234.
